// File: rtl/edge_cell_seq_pkg.sv
// Shared types and default constants for the edge-driven cell sequencer.
package edge_cell_seq_pkg;

  localparam int unsigned DefRows            = 16;
  localparam int unsigned DefAddrW           = 4;
  localparam int unsigned DefDataW           = 8;
  localparam int unsigned DefRefreshInterval = 64;

  typedef enum logic [2:0] {
    StIdle,
    StAccSetup,
    StAccStrobe,
    StAccCapture,
    StRefSetup,
    StRefStrobe
  } state_e;

  typedef enum logic [1:0] {
    KindRead,
    KindWrite,
    KindRefresh
  } strobe_kind_e;

endpackage

// File: rtl/edge_cell_sequencer_if.sv
// Request side and cell-array side signals of the edge cell sequencer.
// master: the edge source / array model; slave: the sequencer itself.
interface edge_cell_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              edge_trig;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] cell_read_data;
  logic [ADDR_W-1:0] row_address;
  logic [DATA_W-1:0] cell_write_data;
  logic              read_edge;
  logic              write_edge;
  logic              refresh_edge;
  logic [DATA_W-1:0] read_data_out;
  logic              read_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output edge_trig, write_enable, address, write_data, cell_read_data,
    input  row_address, cell_write_data, read_edge, write_edge, refresh_edge,
    input  read_data_out, read_valid, busy, overrun
  );

  modport slave (
    input  edge_trig, write_enable, address, write_data, cell_read_data,
    output row_address, cell_write_data, read_edge, write_edge, refresh_edge,
    output read_data_out, read_valid, busy, overrun
  );
endinterface

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A level held high yields a single one-cycle pulse, three cycles after arrival.
module edge_sync_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);
  logic sync1_q, sync2_q, prev_q, pulse_q;

  // Synchronize, remember the previous level and register the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/edge_cell_sequencer.sv
// Turns edge pulses into read/write strobes on a dynamic cell row and
// interleaves periodic refresh. One-entry request buffer; refresh wins ties.
// Optional build macro EDGE_SYNC_EN: treat the edge input as asynchronous and
// pass it through edge_sync_detect before it reaches the request buffer.
module edge_cell_sequencer
  import edge_cell_seq_pkg::*;
#(
  parameter int unsigned ROWS             = DefRows,
  parameter int unsigned ADDR_W           = DefAddrW,
  parameter int unsigned DATA_W           = DefDataW,
  parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval
) (
  input logic                  clk,
  input logic                  rst,
  edge_cell_sequencer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] RowLast = ADDR_W'(ROWS - 1);

  logic req_pulse;

`ifdef EDGE_SYNC_EN
  edge_sync_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.edge_trig),
    .pulse    (req_pulse)
  );
`else
  assign req_pulse = bus.edge_trig;
`endif

  state_e            state_q, state_d;
  strobe_kind_e      acc_kind_q, acc_kind_d;
  logic              req_valid_q, req_valid_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ref_ptr_q, ref_ptr_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              read_edge_q, read_edge_d;
  logic              write_edge_q, write_edge_d;
  logic              refresh_edge_q, refresh_edge_d;
  logic              read_valid_q, read_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              drain, clear_pending, wrap;

  // Next-state: FSM, refresh interval, request buffer and registered outputs.
  always_comb begin
    state_d        = state_q;
    acc_kind_d     = acc_kind_q;
    req_valid_d    = req_valid_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_data_d     = req_data_q;
    pending_d      = pending_q;
    ref_ptr_d      = ref_ptr_q;
    row_d          = row_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    read_edge_d    = 1'b0;
    write_edge_d   = 1'b0;
    refresh_edge_d = 1'b0;
    read_valid_d   = 1'b0;
    overrun_d      = 1'b0;
    drain          = 1'b0;
    clear_pending  = 1'b0;
    wrap           = (cnt_q == CntLast);
    cnt_d          = wrap ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d       = StRefSetup;
          row_d         = ref_ptr_q;
          clear_pending = 1'b1;
        end else if (req_valid_q) begin
          // The buffer is emptied on entry to setup so a following edge can land.
          state_d    = StAccSetup;
          row_d      = req_addr_q;
          wdata_d    = req_data_q;
          acc_kind_d = req_we_q ? KindWrite : KindRead;
          drain      = 1'b1;
        end
      end
      StAccSetup: begin
        state_d = StAccStrobe;
        if (acc_kind_q == KindWrite) write_edge_d = 1'b1;
        else                         read_edge_d  = 1'b1;
      end
      StAccStrobe: begin
        if (acc_kind_q == KindWrite) begin
          state_d = StIdle;
        end else begin
          // Array data is valid while the read strobe is high.
          state_d      = StAccCapture;
          rdata_d      = bus.cell_read_data;
          read_valid_d = 1'b1;
        end
      end
      StAccCapture: state_d = StIdle;
      StRefSetup: begin
        state_d        = StRefStrobe;
        refresh_edge_d = 1'b1;
      end
      StRefStrobe: begin
        state_d   = StIdle;
        ref_ptr_d = (ref_ptr_q == RowLast) ? '0 : ref_ptr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A new wrap re-arms refresh even on the cycle the old one is consumed.
    if (wrap)               pending_d = 1'b1;
    else if (clear_pending) pending_d = 1'b0;

    if (req_pulse && req_valid_q && !drain) begin
      overrun_d = 1'b1;
    end else if (req_pulse) begin
      req_valid_d = 1'b1;
      req_we_d    = bus.write_enable;
      req_addr_d  = bus.address;
      req_data_d  = bus.write_data;
    end else if (drain) begin
      req_valid_d = 1'b0;
    end

    busy_d = (state_d != StIdle) || req_valid_d || pending_d;
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      acc_kind_q     <= KindRead;
      req_valid_q    <= 1'b0;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_data_q     <= '0;
      pending_q      <= 1'b0;
      cnt_q          <= '0;
      ref_ptr_q      <= '0;
      row_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      read_edge_q    <= 1'b0;
      write_edge_q   <= 1'b0;
      refresh_edge_q <= 1'b0;
      read_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_kind_q     <= acc_kind_d;
      req_valid_q    <= req_valid_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_data_q     <= req_data_d;
      pending_q      <= pending_d;
      cnt_q          <= cnt_d;
      ref_ptr_q      <= ref_ptr_d;
      row_q          <= row_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      read_edge_q    <= read_edge_d;
      write_edge_q   <= write_edge_d;
      refresh_edge_q <= refresh_edge_d;
      read_valid_q   <= read_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.row_address     = row_q;
  assign bus.cell_write_data = wdata_q;
  assign bus.read_edge       = read_edge_q;
  assign bus.write_edge      = write_edge_q;
  assign bus.refresh_edge    = refresh_edge_q;
  assign bus.read_data_out   = rdata_q;
  assign bus.read_valid      = read_valid_q;
  assign bus.busy            = busy_q;
  assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_edge_cell_sequencer.sv
// Scoreboard bench for edge_cell_sequencer: stimulus pushes expected events
// (kind, cycle, row, data) and a negedge monitor pops and compares them.
module tb_edge_cell_sequencer;
  typedef enum int {EvRead, EvWrite, EvRefresh, EvValid, EvOverrun} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       row;
    int       data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   rel = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  edge_cell_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  edge_cell_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(ev_kind_e k);
    case (k)
      EvRead:    return "read_edge";
      EvWrite:   return "write_edge";
      EvRefresh: return "refresh_edge";
      EvValid:   return "read_valid";
      default:   return "overrun";
    endcase
  endfunction

  task automatic push(ev_kind_e k, int c, int row, int data);
    ev_t e;
    e.kind = k; e.cyc = c; e.row = row; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(ev_kind_e k, int row, int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %s cyc=%0d row=%0d data=%0h required none",
               kname(k), cyc, row, data);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || (e.row >= 0 && e.row != row) ||
        (e.data >= 0 && e.data != data)) begin
      errors++;
      $display("FAIL event got %s cyc=%0d row=%0d data=%0h required %s cyc=%0d row=%0d data=%0h",
               kname(k), cyc, row, data, kname(e.kind), e.cyc, e.row, e.data);
    end
  endtask

  task automatic chk(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, actual, required);
    end
  endtask

  // Monitor: every observed strobe/qualifier pops one expected event.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones({bus.read_edge, bus.write_edge, bus.refresh_edge}) > 1) begin
        errors++;
        $display("FAIL strobe_exclusive cyc=%0d got %b required at most one",
                 cyc, {bus.read_edge, bus.write_edge, bus.refresh_edge});
      end
      if (bus.write_edge)   check_ev(EvWrite, bus.row_address, bus.cell_write_data);
      if (bus.read_edge)    check_ev(EvRead, bus.row_address, 0);
      if (bus.refresh_edge) check_ev(EvRefresh, bus.row_address, 0);
      if (bus.read_valid)   check_ev(EvValid, 0, bus.read_data_out);
      if (bus.overrun)      check_ev(EvOverrun, 0, 0);
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
  endtask

  // One-cycle edge pulse, driven on a negedge.
  task automatic pulse(logic we, logic [3:0] a, logic [7:0] d);
    bus.edge_trig    = 1'b1;
    bus.write_enable = we;
    bus.address      = a;
    bus.write_data   = d;
    @(negedge clk);
    bus.edge_trig    = 1'b0;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.edge_trig      = 1'b0;
    bus.write_enable   = 1'b0;
    bus.address        = '0;
    bus.write_data     = '0;
    bus.cell_read_data = 8'h3C;
    apply_reset();

    chk("reset_row", int'(bus.row_address), 0);
    chk("reset_wdata", int'(bus.cell_write_data), 0);
    chk("reset_rdata", int'(bus.read_data_out), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_strobes", int'({bus.read_edge, bus.write_edge, bus.refresh_edge,
                                bus.read_valid, bus.overrun}), 0);

    // Write row 5 with A5: strobe at k+2.
    push(EvWrite, rel + 3, 5, 'hA5);
    pulse(1'b1, 4'd5, 8'hA5);
    chk("busy_after_edge", int'(bus.busy), 1);

    // Read row 3: strobe at k+2, data valid at k+3.
    wait_until(rel + 8);
    push(EvRead, rel + 11, 3, -1);
    push(EvValid, rel + 12, -1, 'h3C);
    pulse(1'b0, 4'd3, 8'h00);

    // Reset in the read strobe cycle: no read_valid, outputs cleared at once.
    wait_until(rel + 16);
    push(EvRead, rel + 19, 9, -1);
    pulse(1'b0, 4'd9, 8'h5A);
    wait_until(rel + 19);
    #2 rst = 1'b1;
    #1;
    chk("abort_row", int'(bus.row_address), 0);
    chk("abort_wdata", int'(bus.cell_write_data), 0);
    chk("abort_rdata", int'(bus.read_data_out), 0);
    chk("abort_read_edge", int'(bus.read_edge), 0);
    chk("abort_busy", int'(bus.busy), 0);
    apply_reset();

    // Three back-to-back edges: third one dropped with overrun.
    push(EvWrite, rel + 3, 1, 'h11);
    push(EvOverrun, rel + 3, -1, -1);
    push(EvWrite, rel + 6, 2, 'h22);
    pulse(1'b1, 4'd1, 8'h11);
    pulse(1'b1, 4'd2, 8'h22);
    pulse(1'b1, 4'd4, 8'h44);
    wait_until(rel + 20);
    chk("busy_drained", int'(bus.busy), 0);

    // Edge on the same clock as the first refresh request: refresh goes first.
    apply_reset();
    wait_until(rel + 63);
    push(EvRefresh, rel + 66, 0, -1);
    push(EvWrite, rel + 69, 7, 'h77);
    pulse(1'b1, 4'd7, 8'h77);
    wait_until(rel + 80);

    // Idle refresh sweep across all rows and back to 0.
    apply_reset();
    for (int n = 0; n < 17; n++) push(EvRefresh, rel + 66 + 64 * n, n % 16, -1);
    wait_until(rel + 66 + 64 * 16 + 4);
    chk("refresh_wdata_held", int'(bus.cell_write_data), 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d outstanding required 0 (next %s at cyc %0d)",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_cell_sequencer.md
# edge_cell_sequencer

Downstream consumer of the positive-edge detector stage. It turns each `Edge` pulse into one read or write access on a dynamic SRAM cell row. It also interleaves periodic refresh cycles, driving the `ReadEdge`, `WriteEdge` and `RefreshEdge` strobes plus the row address into the cell array. A one-entry request buffer decouples edge arrival from refresh arbitration.

## Interface
- `ROWS`, 16: number of cell rows (power of two).
- `ADDR_W`, 4: row address width, equal to log2(ROWS).
- `DATA_W`, 8: cell data width.
- `REFRESH_INTERVAL`, 64: Clock cycles between refresh requests, at least 8.

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Edge`  in  1  access trigger from the edge detector.
- `WriteEnable`  in  1  sampled with `Edge`: 1 = write, 0 = read.
- `Address`  in  ADDR_W  sampled with `Edge`.
- `WriteData`  in  DATA_W  sampled with `Edge`.
- `CellReadData`  in  DATA_W  data returned by the array.
- `RowAddress`  out  ADDR_W  row under access or refresh.
- `CellWriteData`  out  DATA_W  data driven to the array.
- `ReadEdge`, `WriteEdge`, `RefreshEdge`  out  1 each  one-cycle array strobes.
- `ReadDataOut`  out  DATA_W  captured read data.
- `ReadValid`  out  1  one-cycle qualifier for `ReadDataOut`.
- `Busy`  out  1  high when state ≠ IDLE or any request is pending.
- `Overrun`  out  1  one-cycle pulse when an `Edge` is dropped.

## Operation
- **Reset:** `Reset` high forces state IDLE and clears every output, the request buffer, `RefreshPending`, the interval counter and the refresh row pointer to 0, regardless of any access in flight.
- **Request buffer:** `Edge` sampled high sets `ReqValid` and latches `WriteEnable`, `Address` and `WriteData`.
  - If `ReqValid` is already set, the request is dropped and `Overrun` pulses for one cycle.
  - If the buffer drains on the same edge, the new request is accepted.
- **Interval counter:** runs 0..REFRESH_INTERVAL-1 and wraps. Each wrap sets `RefreshPending`. A wrap while a refresh is already pending is absorbed.
- **States:** IDLE, ACC_SETUP, ACC_STROBE, ACC_CAPTURE, REF_SETUP, REF_STROBE.
- **IDLE:**
  - If `RefreshPending` is set, go to REF_SETUP. Refresh wins a tie with a pending access.
  - Else if `ReqValid` is set, go to ACC_SETUP.
- **ACC_SETUP:** drive `RowAddress`=buffered address and `CellWriteData`=buffered data; clear `ReqValid`; go to ACC_STROBE.
- **ACC_STROBE:** pulse `WriteEdge` or `ReadEdge` for one cycle.
  - Write: go to IDLE.
  - Read: go to ACC_CAPTURE.
- **ACC_CAPTURE:** register `CellReadData` into `ReadDataOut`, pulse `ReadValid` for one cycle, go to IDLE.
- **REF_SETUP:** drive `RowAddress`=refresh pointer; clear `RefreshPending`; go to REF_STROBE.
- **REF_STROBE:** pulse `RefreshEdge` for one cycle; increment the pointer, wrapping ROWS-1 to 0; go to IDLE.
- **Mutual exclusion:** at most one of the three strobes is high in any cycle.
- **Output hold:** `RowAddress` and `CellWriteData` hold their values between accesses.

## Timing
- All outputs are registered.
- `Edge` sampled at edge k (no sync, IDLE, no refresh pending):
  - ACC_SETUP from k+1.
  - Strobe high k+2 to k+3.
  - Read only: `ReadValid` high k+3 to k+4.
- Write occupies 3 cycles from IDLE to IDLE; read occupies 4; refresh occupies 3.
- Worst-case access wait behind a refresh is 3 extra cycles.
- Throughput: one access per 3–4 cycles. Back-to-back edges arriving faster than that overrun the buffer.

## Configuration
- **With `EDGE_SYNC_EN` defined:**
  - `Edge` is treated as asynchronous and passes through a two-flop synchronizer plus a rising-edge detector, adding 3 cycles of latency.
  - A level held high counts as one request.
  - `WriteEnable`, `Address` and `WriteData` are captured when the detected pulse fires and must be stable through that cycle.
- **Without it:** `Edge` is a synchronous pulse, and every cycle it is sampled high is a separate request.

## Structure
- **Package `edge_cell_seq_pkg`:** the state enumeration, the strobe-kind enumeration (READ, WRITE, REFRESH), and the default parameter constants.
- **Sub-module `edge_sync_detect`:** the synchronizer and detector, instantiated only under `EDGE_SYNC_EN`.

## Test plan
- Reset, then `Edge` with WriteEnable=1, Address=5, WriteData=0xA5 → `WriteEdge` one cycle at k+2 with `RowAddress`=5 and `CellWriteData`=0xA5.
- Read of row 3 with `CellReadData`=0x3C → `ReadEdge` at k+2, then `ReadValid` at k+3 with `ReadDataOut`=0x3C.
- Idle for 64 cycles × 17 refreshes → `RefreshEdge` every 64 cycles with `RowAddress` 0,1,…,15,0 (wrap).
- `Edge` in the same cycle `RefreshPending` sets → `RefreshEdge` first, access strobe 3 cycles later.
- Three `Edge` pulses on consecutive cycles → first two serviced, third dropped with `Overrun` pulse.
- `Reset` asserted during ACC_STROBE of a read → no `ReadValid`, all outputs 0 immediately, `Busy`=0.
